// File: rtl/alu32.sv
// Registered two-operand integer ALU (add, sub, and, or) with status flags.
// Define ALU_INPUT_REG_EN to add an input register stage (2-cycle latency).
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [1:0]       ops;
    logic             opv;

`ifdef ALU_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            opa <= '0;
            opb <= '0;
            ops <= '0;
            opv <= 1'b0;
        end else begin
            opa <= a;
            opb <= b;
            ops <= sel;
            opv <= in_valid;
        end
    end
`else
    assign opa = a;
    assign opb = b;
    assign ops = sel;
    assign opv = in_valid;
`endif

    logic op_add;
    logic op_sub;
    logic op_and;
    logic op_or;

    assign op_add = (ops == 2'd0);
    assign op_sub = (ops == 2'd1);
    assign op_and = (ops == 2'd2);
    assign op_or  = (ops == 2'd3);

    // Extra top bit carries the add carry-out or the subtract borrow.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = {1'b0, opa} - {1'b0, opb};

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    assign sa = opa[WIDTH-1];
    assign sb = opb[WIDTH-1];

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (1'b1)
            op_add: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (sa == sb) && (sum[WIDTH-1] != sa);
            end
            op_sub: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (sa != sb) && (diff[WIDTH-1] != sa);
            end
            op_and: begin
                res = opa & opb;
            end
            op_or: begin
                res = opa | opb;
            end
            default: begin
                res   = '0;
                res_c = 1'b0;
                res_v = 1'b0;
            end
        endcase
    end

    // Idle cycles keep the last result and flags; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else if (opv) begin
            out       <= res;
            out_valid <= 1'b1;
            zero      <= (res == '0);
            negative  <= res[WIDTH-1];
            carry     <= res_c;
            overflow  <= res_v;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed cases plus counting/random
// stimulus checked every cycle against an arithmetic reference model.
module tb_alu32;

`ifdef ALU_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  sel = '0;
    logic [31:0] out;
    logic        out_valid;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    alu32 #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .sel(sel),
        .out(out),
        .out_valid(out_valid),
        .zero(zero),
        .negative(negative),
        .carry(carry),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
    } rec_t;

    rec_t q[$];

    logic [31:0] m_out = '0;
    logic        m_ov  = 1'b0;
    logic        m_z   = 1'b0;
    logic        m_n   = 1'b0;
    logic        m_c   = 1'b0;
    logic        m_v   = 1'b0;

    localparam longint SMAX = (longint'(1) <<< 31) - 1;
    localparam longint SMIN = -(longint'(1) <<< 31);

    function automatic void ref_op(input logic [31:0] x, input logic [31:0] y,
                                   input logic [1:0] s, output logic [31:0] r,
                                   output logic c, output logic v);
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint unsigned full;
        longint sr;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            2'd0: begin
                full = ux + uy;
                r = full[31:0];
                c = (full > 64'hFFFF_FFFF);
                sr = sx + sy;
                v = (sr > SMAX) || (sr < SMIN);
            end
            2'd1: begin
                r = x - y;
                c = (ux < uy);
                sr = sx - sy;
                v = (sr > SMAX) || (sr < SMIN);
            end
            2'd2: r = x & y;
            default: r = x | y;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rec_t idle;
        idle = '{rst: 1'b0, vld: 1'b0, a: '0, b: '0, sel: '0};
        m_out = '0;
        m_ov  = 1'b0;
        m_z   = 1'b0;
        m_n   = 1'b0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        q.delete();
        repeat (LAT - 1) q.push_back(idle);
    endtask

    // One clock: record inputs, advance model, compare all outputs.
    task automatic tick();
        rec_t cur;
        rec_t r;
        logic [31:0] res;
        logic c;
        logic v;
        cur = '{rst: rst, vld: in_valid, a: a, b: b, sel: sel};
        @(posedge clk);
        #1;
        if (cur.rst) begin
            model_reset();
        end else begin
            q.push_back(cur);
            r = q.pop_front();
            if (r.vld) begin
                ref_op(r.a, r.b, r.sel, res, c, v);
                m_out = res;
                m_ov  = 1'b1;
                m_z   = (res == 32'd0);
                m_n   = res[31];
                m_c   = c;
                m_v   = v;
            end else begin
                m_ov = 1'b0;
            end
        end
        chk("out", out, m_out);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("zero", {31'd0, zero}, {31'd0, m_z});
        chk("negative", {31'd0, negative}, {31'd0, m_n});
        chk("carry", {31'd0, carry}, {31'd0, m_c});
        chk("overflow", {31'd0, overflow}, {31'd0, m_v});
    endtask

    task automatic op_check(input string tag, input logic [31:0] x,
                            input logic [31:0] y, input logic [1:0] s,
                            input logic [31:0] e_out, input logic e_c,
                            input logic e_v, input logic e_z,
                            input logic e_n);
        a = x;
        b = y;
        sel = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        chk({tag, ".out"}, out, e_out);
        chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".c"}, {31'd0, carry}, {31'd0, e_c});
        chk({tag, ".v"}, {31'd0, overflow}, {31'd0, e_v});
        chk({tag, ".z"}, {31'd0, zero}, {31'd0, e_z});
        chk({tag, ".n"}, {31'd0, negative}, {31'd0, e_n});
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset mid-stream: a pending op then reset with valid inputs.
        a = 32'd9; b = 32'd1; sel = 2'd1; in_valid = 1'b1;
        tick();
        a = 32'd5; b = 32'd3; sel = 2'd0; rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst.out", out, 32'd0);
        chk("rst.vld", {31'd0, out_valid}, 32'd0);
        chk("rst.flags", {28'd0, zero, negative, carry, overflow}, 32'd0);
        repeat (2) tick();

        op_check("add", 32'd10, 32'd2, 2'd0, 32'd12, 0, 0, 0, 0);
        op_check("addwrap", 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0, 1, 0, 1, 0);
        op_check("addovf", 32'h7FFF_FFFF, 32'd1, 2'd0, 32'h8000_0000,
                 0, 1, 0, 1);
        op_check("sub", 32'd5, 32'd7, 2'd1, 32'hFFFF_FFFE, 1, 0, 0, 1);
        op_check("subovf", 32'h8000_0000, 32'd1, 2'd1, 32'h7FFF_FFFF,
                 0, 1, 0, 0);
        op_check("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'd2, 32'h00F0_00F0,
                 0, 0, 0, 0);
        op_check("or", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'd3, 32'hFFF0_FFF0,
                 0, 0, 0, 1);

        // Idle hold after 3 + 4.
        op_check("hold0", 32'd3, 32'd4, 2'd0, 32'd7, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.out", out, 32'd7);
            chk("hold.vld", {31'd0, out_valid}, 32'd0);
        end

        // Counting stimulus across all four operations.
        a = $urandom;
        b = $urandom;
        in_valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            a = a + 32'd1;
            if (i % 5 == 0) b = b + 32'd1;
            sel = 2'(i / 30);
            tick();
        end

        // Random operands, ops and gaps, with one reset inside the burst.
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = (i % 7 == 0) ? a : $urandom;
            sel = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            rst = (i == 100);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (LAT + 1) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
